msx_io_bus_router: RTL and testbench

- Routes the single MSX-slot-side request bus (bus_* from msx_slot, clk42m domain) to up to four I/O target devices.
- Examples: test_controller at 88h-8Bh, UART/GPIO at 10h-11h, future VDP ports.
- Decodes I/O port windows, sequences the per-device valid/ready handshake and muxes read data back.
- Answers unmapped and memory requests locally: writes dropped, reads return FFh.

---
 rtl/msx_io_bus_router.sv | 161 ++++++++++++++++
 tb/tb_msx_io_bus_router.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msx_io_bus_router.sv
`default_nettype none
// ============================================================================
// msx_io_bus_router : MSX slot I/O request router to four port-window devices
// Optional handshake timeout: define IO_ROUTER_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
module msx_io_bus_router #(
  parameter logic [7:0] DEV0_BASE = 8'h88,
  parameter logic [7:0] DEV0_MASK = 8'hFC,
  parameter logic [7:0] DEV1_BASE = 8'h10,
  parameter logic [7:0] DEV1_MASK = 8'hFE,
  parameter logic [7:0] DEV2_BASE = 8'h00,
  parameter logic [7:0] DEV2_MASK = 8'h00,
  parameter logic [7:0] DEV3_BASE = 8'h00,
  parameter logic [7:0] DEV3_MASK = 8'h00,
  parameter int         TIMEOUT   = 64
) (
  input  logic        clk42m,
  input  logic        reset_n,
  input  logic        bus_memreq,
  input  logic        bus_ioreq,
  input  logic [15:0] bus_address,
  input  logic        bus_write,
  input  logic        bus_valid,
  output logic        bus_ready,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  output logic        bus_rdata_en,
  output logic [7:0]  dev_address,
  output logic        dev_write,
  output logic [7:0]  dev_wdata,
  output logic [3:0]  dev_valid,
  input  logic [3:0]  dev_ready,
  input  logic [31:0] dev_rdata,
  input  logic [3:0]  dev_rdata_en,
  output logic        err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_WAIT_RD = 2'd2,
    S_LOCAL   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_ready;
  logic [1:0]  r_sel;
  logic [7:0]  r_addr;
  logic        r_write;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;
  logic        r_rdata_en;
  logic        r_err;
  logic [3:0]  w_hits;
  logic        w_hit;
  logic [1:0]  w_hit_idx;
  logic        w_accept;
  logic        w_dev_ack;
  logic        w_timeout;
  logic        w_unused;

  assign w_hits[0] = bus_ioreq & (DEV0_MASK != 8'h00) &
                     ((bus_address[7:0] & DEV0_MASK) == (DEV0_BASE & DEV0_MASK));
  assign w_hits[1] = bus_ioreq & (DEV1_MASK != 8'h00) &
                     ((bus_address[7:0] & DEV1_MASK) == (DEV1_BASE & DEV1_MASK));
  assign w_hits[2] = bus_ioreq & (DEV2_MASK != 8'h00) &
                     ((bus_address[7:0] & DEV2_MASK) == (DEV2_BASE & DEV2_MASK));
  assign w_hits[3] = bus_ioreq & (DEV3_MASK != 8'h00) &
                     ((bus_address[7:0] & DEV3_MASK) == (DEV3_BASE & DEV3_MASK));

  assign w_hit     = (|w_hits) & ~bus_memreq;
  assign w_hit_idx = w_hits[0] ? 2'd0 : w_hits[1] ? 2'd1 : w_hits[2] ? 2'd2 : 2'd3;
  assign w_accept  = bus_valid & r_ready;

  // The event being waited for depends only on the state; other devices are ignored.
  assign w_dev_ack = (r_state == S_ACCESS) ? dev_ready[r_sel] : dev_rdata_en[r_sel];

`ifdef IO_ROUTER_TIMEOUT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk42m) begin
    if (!reset_n)               r_cnt <= 8'd0;
    else if (w_next != r_state) r_cnt <= 8'd0;
    else                        r_cnt <= r_cnt + 8'd1;
  end

  assign w_timeout = ((r_state == S_ACCESS) || (r_state == S_WAIT_RD)) &&
                     !w_dev_ack && (r_cnt == 8'(TIMEOUT - 1));
  assign w_unused  = ^bus_address[15:8];
`else
  assign w_timeout = 1'b0;
  assign w_unused  = (^bus_address[15:8]) ^ (TIMEOUT > 1);
`endif

  always_ff @(posedge clk42m) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_hit ? S_ACCESS : S_LOCAL;
      S_ACCESS:  if (w_dev_ack) w_next = r_write ? S_IDLE : S_WAIT_RD;
                 else if (w_timeout) w_next = S_IDLE;
      S_WAIT_RD: if (w_dev_ack || w_timeout) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Response strobes are registered so they land in the cycle after the decision.
  always_ff @(posedge clk42m) begin
    if (!reset_n) begin
      r_ready    <= 1'b0;
      r_sel      <= 2'd0;
      r_addr     <= 8'h00;
      r_write    <= 1'b0;
      r_wdata    <= 8'h00;
      r_rdata    <= 8'h00;
      r_rdata_en <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_ready    <= (w_next == S_IDLE);
      r_rdata_en <= 1'b0;
      r_err      <= 1'b0;
      if (w_accept) begin
        r_addr  <= bus_address[7:0];
        r_write <= bus_write;
        r_wdata <= bus_wdata;
        r_sel   <= w_hit_idx;
        if (!w_hit && !bus_write) begin
          r_rdata    <= 8'hFF;
          r_rdata_en <= 1'b1;
        end
      end
      if ((r_state == S_WAIT_RD) && w_dev_ack) begin
        r_rdata    <= dev_rdata[{r_sel, 3'b000} +: 8];
        r_rdata_en <= 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
        if (!r_write) begin
          r_rdata    <= 8'hFF;
          r_rdata_en <= 1'b1;
        end
      end
    end
  end

  assign bus_ready    = r_ready;
  assign bus_rdata    = r_rdata;
  assign bus_rdata_en = r_rdata_en;
  assign dev_address  = r_addr;
  assign dev_write    = r_write;
  assign dev_wdata    = r_wdata;
  assign dev_valid    = (r_state == S_ACCESS) ? (4'b0001 << r_sel) : 4'b0000;
  assign err_timeout  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_msx_io_bus_router.sv
`default_nettype none
// ============================================================================
// tb_msx_io_bus_router : randomized transaction bench with a port-window model
// Revision: 1.0
// ============================================================================
module tb_msx_io_bus_router;

  logic        clk42m = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_memreq = 1'b0;
  logic        bus_ioreq = 1'b0;
  logic [15:0] bus_address = 16'h0;
  logic        bus_write = 1'b0;
  logic        bus_valid = 1'b0;
  logic        bus_ready;
  logic [7:0]  bus_wdata = 8'h0;
  logic [7:0]  bus_rdata;
  logic        bus_rdata_en;
  logic [7:0]  dev_address;
  logic        dev_write;
  logic [7:0]  dev_wdata;
  logic [3:0]  dev_valid;
  logic [3:0]  dev_ready = 4'h0;
  logic [31:0] dev_rdata = 32'h0;
  logic [3:0]  dev_rdata_en = 4'h0;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk42m = ~clk42m;

  msx_io_bus_router #(
    .DEV2_BASE(8'h88), .DEV2_MASK(8'hFF),
    .DEV3_BASE(8'h98), .DEV3_MASK(8'hF8),
    .TIMEOUT(16)
  ) u_dut (
    .clk42m(clk42m), .reset_n(reset_n),
    .bus_memreq(bus_memreq), .bus_ioreq(bus_ioreq), .bus_address(bus_address),
    .bus_write(bus_write), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en),
    .dev_address(dev_address), .dev_write(dev_write), .dev_wdata(dev_wdata),
    .dev_valid(dev_valid), .dev_ready(dev_ready), .dev_rdata(dev_rdata),
    .dev_rdata_en(dev_rdata_en), .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Window table mirrors the instance parameters above; first match wins.
  function automatic int exp_sel(input logic mem, input logic io, input logic [7:0] a);
    logic [7:0] base [4];
    logic [7:0] mask [4];
    base = '{8'h88, 8'h10, 8'h88, 8'h98};
    mask = '{8'hFC, 8'hFE, 8'hFF, 8'hF8};
    if (mem || !io) return -1;
    for (int i = 0; i < 4; i++)
      if (mask[i] != 8'h00 && (a & mask[i]) == (base[i] & mask[i])) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk42m);
    #1;
  endtask

  task automatic start(input logic mem, input logic io, input logic [15:0] addr,
                       input logic wr, input logic [7:0] wd);
    int guard;
    guard = 0;
    while (!bus_ready && guard < 20) begin
      step();
      guard++;
    end
    chk("ready_before", {31'd0, bus_ready}, 32'd1);
    bus_memreq = mem; bus_ioreq = io; bus_address = addr;
    bus_write = wr; bus_wdata = wd; bus_valid = 1'b1;
    step();
    bus_valid = 1'b0; bus_memreq = 1'b0; bus_ioreq = 1'b0;
    bus_address = 16'($urandom); bus_wdata = 8'($urandom);
    chk("ready_busy", {31'd0, bus_ready}, 32'd0);
  endtask

  task automatic do_txn(input logic mem, input logic io, input logic [15:0] addr,
                        input logic wr, input logic [7:0] wd, input int rdly,
                        input int ddly, input logic [7:0] rd, input logic both);
    int s;
    logic [3:0] oh;
    s = exp_sel(mem, io, addr[7:0]);
    start(mem, io, addr, wr, wd);
    if (s < 0) begin
      chk("loc_valid", {28'd0, dev_valid}, 32'd0);
      chk("loc_rden", {31'd0, bus_rdata_en}, {31'd0, !wr});
      if (!wr) chk("loc_rdata", {24'd0, bus_rdata}, 32'hFF);
      step();
      chk("loc_ready", {31'd0, bus_ready}, 32'd1);
      chk("loc_rden_off", {31'd0, bus_rdata_en}, 32'd0);
    end else begin
      oh = 4'b0001 << s;
      chk("acc_addr", {24'd0, dev_address}, {24'd0, addr[7:0]});
      chk("acc_write", {31'd0, dev_write}, {31'd0, wr});
      if (wr) chk("acc_wdata", {24'd0, dev_wdata}, {24'd0, wd});
      for (int i = 0; i < rdly; i++) begin
        chk("acc_valid", {28'd0, dev_valid}, {28'd0, oh});
        dev_ready = 4'($urandom) & ~oh;
        step();
      end
      chk("acc_valid", {28'd0, dev_valid}, {28'd0, oh});
      dev_ready = oh;
      if (both && !wr) begin
        dev_rdata_en = oh;
        dev_rdata = {4{~rd}};
      end
      step();
      dev_ready = 4'h0; dev_rdata_en = 4'h0;
      chk("acc_drop", {28'd0, dev_valid}, 32'd0);
      if (wr) begin
        chk("wr_ready", {31'd0, bus_ready}, 32'd1);
        chk("wr_rden", {31'd0, bus_rdata_en}, 32'd0);
      end else begin
        for (int i = 0; i < ddly; i++) begin
          chk("wt_rden", {31'd0, bus_rdata_en}, 32'd0);
          chk("wt_ready", {31'd0, bus_ready}, 32'd0);
          dev_rdata_en = 4'($urandom) & ~oh;
          dev_rdata = $urandom;
          step();
        end
        chk("wt_rden", {31'd0, bus_rdata_en}, 32'd0);
        dev_rdata = $urandom;
        dev_rdata[s*8 +: 8] = rd;
        dev_rdata_en = oh | (4'($urandom) & ~oh);
        step();
        dev_rdata_en = 4'h0;
        chk("rd_en", {31'd0, bus_rdata_en}, 32'd1);
        chk("rd_data", {24'd0, bus_rdata}, {24'd0, rd});
        chk("rd_ready", {31'd0, bus_ready}, 32'd1);
        step();
        chk("rd_en_off", {31'd0, bus_rdata_en}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] pool [12];
    logic [7:0] a;
    pool = '{8'h88, 8'h89, 8'h8A, 8'h8B, 8'h10, 8'h11, 8'h12, 8'h40,
             8'h98, 8'h9F, 8'hA0, 8'h00};

    // Reset state
    repeat (3) step();
    chk("rst_ready", {31'd0, bus_ready}, 32'd0);
    chk("rst_rdata", {24'd0, bus_rdata}, 32'd0);
    chk("rst_rden", {31'd0, bus_rdata_en}, 32'd0);
    chk("rst_valid", {28'd0, dev_valid}, 32'd0);
    chk("rst_addr", {24'd0, dev_address}, 32'd0);
    chk("rst_wdata", {24'd0, dev_wdata}, 32'd0);
    chk("rst_write", {31'd0, dev_write}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    reset_n = 1'b1;
    step();
    chk("rel_ready", {31'd0, bus_ready}, 32'd1);

    // Directed cases
    do_txn(1'b0, 1'b1, 16'h0088, 1'b1, 8'h5A, 0, 0, 8'h00, 1'b0);
    do_txn(1'b0, 1'b1, 16'h0011, 1'b0, 8'h00, 3, 5, 8'h3C, 1'b0);
    do_txn(1'b0, 1'b1, 16'h0040, 1'b0, 8'h00, 0, 0, 8'h00, 1'b0);
    do_txn(1'b1, 1'b0, 16'h4000, 1'b0, 8'h00, 0, 0, 8'h00, 1'b0);
    do_txn(1'b1, 1'b1, 16'h0088, 1'b0, 8'h00, 0, 0, 8'h00, 1'b0);
    do_txn(1'b0, 1'b1, 16'h0040, 1'b1, 8'h77, 0, 0, 8'h00, 1'b0);
    do_txn(1'b0, 1'b1, 16'h0088, 1'b0, 8'h00, 0, 0, 8'hC3, 1'b0);
    do_txn(1'b0, 1'b1, 16'h0088, 1'b0, 8'h00, 1, 4, 8'h96, 1'b1);
    do_txn(1'b0, 1'b1, 16'h009C, 1'b0, 8'h00, 2, 1, 8'h21, 1'b0);

    // Device never answers
    start(1'b0, 1'b1, 16'h0089, 1'b0, 8'h00);
`ifdef IO_ROUTER_TIMEOUT_EN
    for (int i = 1; i < 16; i++) step();
    chk("to_valid", {28'd0, dev_valid}, 32'd1);
    chk("to_err_early", {31'd0, err_timeout}, 32'd0);
    step();
    chk("to_err", {31'd0, err_timeout}, 32'd1);
    chk("to_rden", {31'd0, bus_rdata_en}, 32'd1);
    chk("to_rdata", {24'd0, bus_rdata}, 32'hFF);
    chk("to_drop", {28'd0, dev_valid}, 32'd0);
    step();
    chk("to_err_off", {31'd0, err_timeout}, 32'd0);
`else
    for (int i = 0; i < 1000; i++) step();
    chk("hold_valid", {28'd0, dev_valid}, 32'd1);
    chk("hold_ready", {31'd0, bus_ready}, 32'd0);
    chk("hold_err", {31'd0, err_timeout}, 32'd0);
    dev_ready = 4'b0001;
    step();
    dev_ready = 4'h0;
    dev_rdata = 32'h0000_00E7;
    dev_rdata_en = 4'b0001;
    step();
    dev_rdata_en = 4'h0;
    chk("hold_rden", {31'd0, bus_rdata_en}, 32'd1);
    chk("hold_rdata", {24'd0, bus_rdata}, 32'hE7);
`endif

    // Reset while waiting for read data
    start(1'b0, 1'b1, 16'h0011, 1'b0, 8'h00);
    dev_ready = 4'b0010;
    step();
    dev_ready = 4'h0;
    reset_n = 1'b0;
    dev_rdata = 32'h0000_5500;
    dev_rdata_en = 4'b0010;
    step();
    reset_n = 1'b1;
    dev_rdata_en = 4'h0;
    chk("mrst_valid", {28'd0, dev_valid}, 32'd0);
    chk("mrst_rden", {31'd0, bus_rdata_en}, 32'd0);
    chk("mrst_ready", {31'd0, bus_ready}, 32'd0);
    chk("mrst_rdata", {24'd0, bus_rdata}, 32'd0);
    step();
    chk("mrst_ready1", {31'd0, bus_ready}, 32'd1);
    chk("mrst_rden1", {31'd0, bus_rdata_en}, 32'd0);
    do_txn(1'b0, 1'b1, 16'h0010, 1'b1, 8'hA5, 1, 0, 8'h00, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      logic mem;
      logic io;
      a = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      mem = ($urandom_range(0, 7) == 0);
      io  = mem ? 1'($urandom) : ($urandom_range(0, 9) != 0);
      do_txn(mem, io, {8'($urandom), a}, 1'($urandom), 8'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
